// File: rtl/conv_output_layer.sv
// Serializes one parallel conv-pass vector into a FIFO write stream, index 0 first,
// with optional ReLU applied to each word on the way out.
module conv_output_layer #(
    parameter int LAYER_HEIGHT = 3,
    parameter int WORD_SIZE    = 8,
    parameter int RELU         = 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    valid_i,
    output logic                                    yumi_o,
    input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  data_i,
    output logic                                    wen_o,
    input  logic                                    full_i,
    output logic [WORD_SIZE-1:0]                    data_o
);

    localparam int CW = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LAYER_HEIGHT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                                 state_q, state_d;
    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buf_q, buf_d;
    logic                                   yumi, wen;
    logic [WORD_SIZE-1:0]                   word;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        yumi    = 1'b0;
        wen     = 1'b0;
        case (state_q)
            IDLE: begin
                yumi = valid_i;
                if (valid_i) begin
                    buf_d   = data_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                wen = !full_i;
                if (wen) begin
                    if (cnt_q == LAST) begin
                        // Chain straight into the next vector so there is no bubble.
                        cnt_d = '0;
                        if (valid_i) begin
                            yumi  = 1'b1;
                            buf_d = data_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low for the whole time reset is held.
    assign yumi_o = yumi & ~reset_i;
    assign wen_o  = wen & ~reset_i;

    assign word   = buf_q[cnt_q];
    assign data_o = (RELU != 0 && word[WORD_SIZE-1]) ? '0 : word;

endmodule

// File: tb/tb_conv_output_layer.sv
// Directed bench for conv_output_layer: a RELU=1 and a RELU=0 instance share stimulus,
// and a negedge monitor pops per-instance expected-write queues.
module tb_conv_output_layer;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid;
    logic            full;
    logic [1:0][7:0] din;
    logic            yumi1, wen1, yumi2, wen2;
    logic [7:0]      d1, d2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    conv_output_layer #(.LAYER_HEIGHT(2), .WORD_SIZE(8), .RELU(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid), .yumi_o(yumi1),
        .data_i(din), .wen_o(wen1), .full_i(full), .data_o(d1)
    );

    conv_output_layer #(.LAYER_HEIGHT(2), .WORD_SIZE(8), .RELU(0)) dut2 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid), .yumi_o(yumi2),
        .data_i(din), .wen_o(wen2), .full_i(full), .data_o(d2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push_both(input logic [7:0] e1, input logic [7:0] e2);
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    // Every write either matches the head of its queue or is an unexpected write.
    always @(negedge clk) begin
        logic [7:0] e;
        if (wen1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1 unexpected write: got %h expected none at %0t", d1, $time);
            end else begin
                e = q1.pop_front();
                chk("dut1 write data", d1, e);
            end
        end
        if (wen2) begin
            if (q2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut2 unexpected write: got %h expected none at %0t", d2, $time);
            end else begin
                e = q2.pop_front();
                chk("dut2 write data", d2, e);
            end
        end
    end

    initial begin
        rst = 1'b1; valid = 1'b1; din = 16'h435c; full = 1'b0;
        // reset state, with valid_i high
        step(); at_neg();
        chk("reset yumi", {7'd0, yumi1}, 8'd0);
        chk("reset wen", {7'd0, wen1}, 8'd0);
        chk("reset data1", d1, 8'h00);
        chk("reset data2", d2, 8'h00);
        valid = 1'b0;
        step(); rst = 1'b0;
        at_neg(); chk("idle wen", {7'd0, wen1}, 8'd0);

        // single vector
        step(); valid = 1'b1; din = 16'h435c; push_both(8'h5c, 8'h5c); push_both(8'h43, 8'h43);
        at_neg(); chk("single yumi", {7'd0, yumi1}, 8'd1);
        step(); valid = 1'b0;
        at_neg(); chk("single wen0", {7'd0, wen1}, 8'd1); chk("single yumi0", {7'd0, yumi1}, 8'd0);
        step(); at_neg(); chk("single wen1", {7'd0, wen1}, 8'd1);
        step(); at_neg(); chk("single idle wen", {7'd0, wen1}, 8'd0);

        // ReLU vs pass-through
        step(); valid = 1'b1; din = 16'h807f; push_both(8'h7f, 8'h7f); push_both(8'h00, 8'h80);
        at_neg(); chk("relu yumi", {7'd0, yumi2}, 8'd1);
        step(); valid = 1'b0;
        step(); step();

        // backpressure for 3 cycles after capture
        step(); valid = 1'b1; din = 16'h435c; push_both(8'h5c, 8'h5c); push_both(8'h43, 8'h43);
        at_neg(); chk("bp yumi", {7'd0, yumi1}, 8'd1);
        step(); valid = 1'b0; full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("bp wen held", {7'd0, wen1}, 8'd0);
            chk("bp data held", d1, 8'h5c);
            chk("bp yumi held", {7'd0, yumi1}, 8'd0);
            step();
        end
        full = 1'b0;
        at_neg(); chk("bp resume wen", {7'd0, wen1}, 8'd1); chk("bp resume yumi", {7'd0, yumi1}, 8'd0);
        step(); at_neg(); chk("bp last wen", {7'd0, wen1}, 8'd1); chk("bp last yumi", {7'd0, yumi1}, 8'd0);
        step(); at_neg(); chk("bp idle wen", {7'd0, wen1}, 8'd0);

        // back-to-back vectors
        step(); valid = 1'b1; din = 16'h435c;
        push_both(8'h5c, 8'h5c); push_both(8'h43, 8'h43); push_both(8'h6e, 8'h6e); push_both(8'h7f, 8'h7f);
        at_neg(); chk("b2b yumi first", {7'd0, yumi1}, 8'd1);
        step(); din = 16'h7f6e;
        at_neg(); chk("b2b yumi mid", {7'd0, yumi1}, 8'd0); chk("b2b wen 5c", {7'd0, wen1}, 8'd1);
        step();
        at_neg(); chk("b2b yumi second", {7'd0, yumi1}, 8'd1); chk("b2b wen 43", {7'd0, wen1}, 8'd1);
        step(); valid = 1'b0;
        at_neg(); chk("b2b wen 6e", {7'd0, wen1}, 8'd1); chk("b2b yumi after", {7'd0, yumi1}, 8'd0);
        step(); at_neg(); chk("b2b wen 7f", {7'd0, wen1}, 8'd1);
        step(); at_neg(); chk("b2b idle wen", {7'd0, wen1}, 8'd0);

        // reset mid-transfer, asserted asynchronously mid-cycle
        step(); valid = 1'b1; din = 16'h435c; push_both(8'h5c, 8'h5c);
        at_neg(); chk("mid yumi", {7'd0, yumi1}, 8'd1);
        step(); valid = 1'b0;
        at_neg(); chk("mid wen 5c", {7'd0, wen1}, 8'd1);
        @(posedge clk); #3; rst = 1'b1; valid = 1'b1;
        #1;
        chk("async yumi", {7'd0, yumi1}, 8'd0);
        chk("async wen", {7'd0, wen1}, 8'd0);
        chk("async data1", d1, 8'h00);
        chk("async data2", d2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("in-reset yumi", {7'd0, yumi1}, 8'd0);
            chk("in-reset wen", {7'd0, wen1}, 8'd0);
            chk("in-reset data", d1, 8'h00);
            step();
        end
        valid = 1'b0; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("post-reset wen", {7'd0, wen1}, 8'd0);
            step();
        end

        chk("dut1 pending writes", 8'(q1.size()), 8'd0);
        chk("dut2 pending writes", 8'(q2.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
